// File: rtl/resizer_pkg.sv
// resizer_pkg: lane layout constants, lane size helper and lane type shared by the resizer blocks
package resizer_pkg;
  localparam int LANE_KEEP_BIT = 0;
  localparam int LANE_LAST_BIT = 1;
  localparam int LANE_DATA_LSB = 2;
  localparam int DEF_DATA_WIDTH = 8;
  function automatic int lane_sz(input int t_data_width);
    return t_data_width + LANE_DATA_LSB;
  endfunction
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
    logic                      keep;
  } lane_t;
endpackage

// File: rtl/resizer_tx_stage.sv
// resizer_tx_stage: compaction staging (append kept lanes, merge null-lane last, extract beat, shift down)
// ports: clk/rst_n, entry+accept append an entry, take removes the offered beat, flush forces a partial beat;
// beat_* is the beat on offer, beat_n its lane count, cnt the staged lane count, last_low a last in the low M lanes
import resizer_pkg::*;
module resizer_tx_stage #(
  parameter int M = 2,
  parameter int W = 8,
  localparam int LS = lane_sz(W),
  localparam int S = 2 * M,
  localparam int CW = $clog2(S + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M*LS-1:0] entry,
  input  logic            accept,
  input  logic            take,
  input  logic            flush,
  output logic            beat_valid,
  output logic [M*W-1:0]  beat_data,
  output logic [M-1:0]    beat_keep,
  output logic            beat_last,
  output logic [CW-1:0]   beat_n,
  output logic [CW-1:0]   cnt,
  output logic            last_low
);
  logic [LS-1:0] st [S];
  logic [LS-1:0] nx [S];
  logic [CW-1:0] cnt_nx;
  always_comb begin
    int p;
    p = M - 1;
    last_low = 1'b0;
    for (int i = M - 1; i >= 0; i--)
      if (i < int'(cnt) && st[i][LANE_LAST_BIT]) begin
        p = i;
        last_low = 1'b1;
      end
    if (flush) p = int'(cnt) - 1;
    beat_valid = int'(cnt) >= M || last_low || flush;
    beat_last = 1'b0;
    for (int i = 0; i < M; i++) begin
      beat_data[i*W +: W] = i <= p ? st[i][LANE_DATA_LSB +: W] : '0;
      beat_keep[i] = i <= p && st[i][LANE_KEEP_BIT];
      if (i == p) beat_last = st[i][LANE_LAST_BIT] && !flush;
    end
    beat_n = CW'(p + 1);
  end
  // shift out the taken beat first, then append so the entry lands after what remains
  always_comb begin
    int sh, c;
    logic [LS-1:0] lane;
    sh = take ? int'(beat_n) : 0;
    c = int'(cnt) - sh;
    lane = '0;
    for (int i = 0; i < S; i++) begin
      nx[i] = '0;
      for (int k = 0; k < S; k++) if (k == i + sh) nx[i] = st[k];
    end
    if (accept)
      for (int j = 0; j < M; j++) begin
        lane = entry[j*LS +: LS];
        if (lane[LANE_KEEP_BIT]) begin
          for (int k = 0; k < S; k++) if (k == c) nx[k] = lane;
          c++;
        end else if (lane[LANE_LAST_BIT]) begin
          if (c > 0) begin
            for (int k = 0; k < S; k++) if (k == c - 1) nx[k][LANE_LAST_BIT] = 1'b1;
          end else begin
            // keep=0 marker lane becomes an empty tlast beat
            nx[0] = '0;
            nx[0][LANE_LAST_BIT] = 1'b1;
            c = 1;
          end
        end
      end
    cnt_nx = CW'(c);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < S; i++) st[i] <= '0;
    end else begin
      cnt <= cnt_nx;
      st <= nx;
    end
endmodule

// File: rtl/resizer_tx.sv
// resizer_tx: packs buffer lane entries into AXI-Stream master beats, dropping null lanes, closing beats on last
// ports: clk, rst_n (async active-low), entry_valid/entry/entry_ready from the buffer,
// m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast AXIS master, pkt_count of tlast handshakes
// RESIZER_TX_TIMEOUT_EN: flush a partial beat after TIMEOUT_CYCLES idle cycles
import resizer_pkg::*;
module resizer_tx #(
  parameter int M_KEEP_WIDTH = 2,
  parameter int T_DATA_WIDTH = 8,
  parameter int LANE_SZ = lane_sz(T_DATA_WIDTH),
  parameter int ENTRY_SZ = LANE_SZ * M_KEEP_WIDTH
`ifdef RESIZER_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               entry_valid,
  input  logic [ENTRY_SZ-1:0]                entry,
  output logic                               entry_ready,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] m_tdata,
  output logic [M_KEEP_WIDTH-1:0]            m_tkeep,
  output logic                               m_tlast,
  output logic [15:0]                        pkt_count
);
  localparam int CW = $clog2(2 * M_KEEP_WIDTH + 1);
  logic                                beat_valid, beat_last, last_low, flush, load, take, accept;
  logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] beat_data;
  logic [M_KEEP_WIDTH-1:0]             beat_keep;
  logic [CW-1:0]                       beat_n, cnt;
  assign load = !m_tvalid || m_tready;
  assign take = beat_valid && load;
  assign entry_ready = rst_n && (int'(cnt) - (take ? int'(beat_n) : 0) <= M_KEEP_WIDTH);
  assign accept = entry_valid && entry_ready;
  resizer_tx_stage #(.M(M_KEEP_WIDTH), .W(T_DATA_WIDTH)) u_stage (
    .clk(clk), .rst_n(rst_n), .entry(entry), .accept(accept), .take(take), .flush(flush),
    .beat_valid(beat_valid), .beat_data(beat_data), .beat_keep(beat_keep), .beat_last(beat_last),
    .beat_n(beat_n), .cnt(cnt), .last_low(last_low)
  );
`ifdef RESIZER_TX_TIMEOUT_EN
  logic [15:0] tmo;
  assign flush = tmo == 16'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo <= '0;
    else if (accept || (take && flush)) tmo <= '0;
    else if (!flush && cnt != '0 && int'(cnt) < M_KEEP_WIDTH && !last_low) tmo <= tmo + 16'd1;
`else
  assign flush = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tkeep <= '0;
      m_tlast <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (load) begin
        m_tvalid <= beat_valid;
        m_tdata <= beat_valid ? beat_data : '0;
        m_tkeep <= beat_valid ? beat_keep : '0;
        m_tlast <= beat_valid && beat_last;
      end
      pkt_count <= pkt_count + 16'(m_tvalid && m_tready && m_tlast);
    end
endmodule

// File: tb/tb_resizer_tx.sv
// tb_resizer_tx: randomized scoreboard bench for resizer_tx against a lane-queue reference model
module tb_resizer_tx;
  localparam int M = 2;
  localparam int LS = 10;
  localparam int ES = M * LS;
  typedef struct packed { logic [7:0] d; logic l; } plane_t;
  typedef struct packed { logic [15:0] data; logic [1:0] keep; logic last; } beat_t;
  logic clk, rst_n, entry_valid, entry_ready, m_tvalid, m_tready, m_tlast;
  logic [ES-1:0] entry;
  logic [15:0] m_tdata, pkt_count;
  logic [1:0] m_tkeep;
  int checks, errors, exp_pkts, beats, mode;
  plane_t pend[$];
  beat_t expq[$];
  beat_t b;
  resizer_tx dut (
    .clk(clk), .rst_n(rst_n), .entry_valid(entry_valid), .entry(entry), .entry_ready(entry_ready),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .pkt_count(pkt_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [LS-1:0] ln(input logic k, input logic l, input logic [7:0] d);
    return {d, l, k};
  endfunction
  function automatic void form();
    forever begin
      int n, p;
      beat_t nb;
      n = pend.size();
      p = -1;
      for (int i = 0; i < M && i < n; i++) if (pend[i].l && p < 0) p = i;
      if (p < 0 && n >= M) p = M - 1;
      if (p < 0) break;
      nb = '0;
      for (int i = 0; i <= p; i++) begin
        nb.data[i*8 +: 8] = pend[i].d;
        nb.keep[i] = 1'b1;
      end
      nb.last = pend[p].l;
      for (int i = 0; i <= p; i++) void'(pend.pop_front());
      expq.push_back(nb);
    end
  endfunction
  function automatic void model_accept(input logic [ES-1:0] e);
    logic [LS-1:0] x;
    for (int j = 0; j < M; j++) begin
      x = e[j*LS +: LS];
      if (x[0]) pend.push_back('{d: x[9:2], l: x[1]});
      else if (x[1]) begin
        if (pend.size() > 0) pend[pend.size()-1].l = 1'b1;
        else expq.push_back('{data: 16'h0, keep: 2'b00, last: 1'b1});
      end
    end
    form();
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask
  task automatic send(input logic [ES-1:0] e);
    int n;
    @(negedge clk);
    entry_valid = 1'b1;
    entry = e;
    #1;
    n = 0;
    while (!entry_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!entry_ready) begin
      errors++;
      $display("FAIL send_timeout got ready=0 want ready=1");
    end else model_accept(e);
    @(posedge clk);
    #1;
    entry_valid = 1'b0;
  endtask
  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (expq.size() != 0 && n < maxc) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask
  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask
  always @(negedge clk)
    m_tready = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : ($urandom_range(9) < 7);
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && m_tvalid && m_tready) begin
      beats++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got data=%h keep=%b last=%b want none", m_tdata, m_tkeep, m_tlast);
      end else begin
        b = expq.pop_front();
        if (m_tdata !== b.data || m_tkeep !== b.keep || m_tlast !== b.last) begin
          errors++;
          $display("FAIL beat got data=%h keep=%b last=%b want data=%h keep=%b last=%b",
                   m_tdata, m_tkeep, m_tlast, b.data, b.keep, b.last);
        end
        if (b.last) exp_pkts++;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nr, seen;
    logic [ES-1:0] e;
    logic k, l, anyk;
    checks = 0; errors = 0; exp_pkts = 0; beats = 0; mode = 0;
    rst_n = 1'b0; entry_valid = 1'b0; entry = '0;
    idle(3);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_ready", entry_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send({ln(1, 0, 8'hA2), ln(1, 0, 8'hA1)});
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("latency_tvalid", m_tvalid, 1);
    wait_drain(20);
    send({ln(1, 0, 8'hB1), ln(0, 0, 8'h00)});
    send({ln(0, 0, 8'h00), ln(1, 0, 8'hB2)});
    wait_drain(20);
    send({ln(1, 0, 8'hC2), ln(1, 1, 8'hC1)});
    send({ln(0, 1, 8'h00), ln(1, 0, 8'hC3)});
    wait_drain(20);
    idle(2);
    chk("pkt_after_c", pkt_count, 2);
    send({ln(0, 0, 8'h00), ln(0, 1, 8'h00)});
    send({ln(0, 0, 8'h00), ln(0, 0, 8'h00)});
    wait_drain(20);
    idle(4);
    chk("pkt_after_empty", pkt_count, 3);
    mode = 2;
    nr = 0;
    fork
      for (int i = 0; i < 4; i++) send({ln(1, 0, 8'($urandom)), ln(1, 0, 8'($urandom))});
      begin
        repeat (6) begin
          @(negedge clk);
          #2;
          if (m_tvalid) begin
            checks++;
            if (m_tdata !== expq[0].data || m_tkeep !== expq[0].keep) begin
              errors++;
              $display("FAIL stall_hold got %h/%b want %h/%b", m_tdata, m_tkeep, expq[0].data, expq[0].keep);
            end
          end
          if (entry_valid && !entry_ready) nr++;
        end
        mode = 0;
      end
    join
    chk("stall_backpressure", nr > 0, 1);
    wait_drain(40);
    mode = 1;
    for (int n = 0; n < 300; n++) begin
      e = '0;
      anyk = 1'b0;
      for (int j = 0; j < M; j++) begin
        k = $urandom_range(3) != 0;
        l = k ? $urandom_range(7) == 0 : anyk && $urandom_range(2) == 0;
        e[j*LS +: LS] = ln(k, l, 8'($urandom));
        anyk = anyk | k;
      end
      send(e);
      if ($urandom_range(5) == 0) idle($urandom_range(2));
    end
    send({ln(0, 0, 8'h00), ln(1, 1, 8'h5A)});
    wait_drain(400);
    mode = 0;
    idle(3);
    chk("pkt_random", pkt_count, 16'(exp_pkts));
    send({ln(0, 0, 8'h00), ln(1, 0, 8'hE1)});
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_pkt", pkt_count, 0);
    chk("midrst_ready", entry_ready, 0);
    pend.delete();
    expq.delete();
    exp_pkts = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = beats;
    idle(8);
    chk("midrst_no_partial", beats - seen, 0);
    send({ln(1, 1, 8'hF2), ln(1, 0, 8'hF1)});
    wait_drain(20);
    idle(2);
    chk("pkt_after_rst", pkt_count, 1);
    send({ln(0, 0, 8'h00), ln(1, 0, 8'hD1)});
`ifdef RESIZER_TX_TIMEOUT_EN
    pend.delete();
    expq.push_back('{data: 16'h00D1, keep: 2'b01, last: 1'b0});
    idle(10);
    chk("tmo_not_early", expq.size(), 1);
    wait_drain(60);
`else
    seen = beats;
    idle(100);
    chk("hold_partial", beats - seen, 0);
    send({ln(0, 0, 8'h00), ln(0, 1, 8'h00)});
    wait_drain(20);
    idle(2);
    chk("pkt_after_hold", pkt_count, 2);
`endif
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/resizer_tx.md
Name: resizer_tx

Overview:
- Master-side transmitter of the resizer. It consumes lane entries from the resizer buffer's read port and drives the AXI-Stream master interface.
- Each entry holds ENTRY_LANES lanes of {data, last, keep}. Null lanes (keep=0) are compacted out, and lanes are packed in order into M_KEEP_WIDTH-lane output beats.
- The block closes a beat early on a lane carrying last.

Parameters:
- M_KEEP_WIDTH, 2, lanes per output beat and per input entry (ENTRY_LANES = M_KEEP_WIDTH).
- T_DATA_WIDTH, 8, data bits per lane.
- LANE_SZ, 2+T_DATA_WIDTH, bits per lane. Lane layout: bit0 = keep, bit1 = last, bits [2 +: T_DATA_WIDTH] = data.
- ENTRY_SZ, LANE_SZ*M_KEEP_WIDTH, input entry width. Lane i occupies [i*LANE_SZ +: LANE_SZ].
- TIMEOUT_CYCLES, 16, idle flush threshold (used only with RESIZER_TX_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- entry_valid  in  1  buffer has an entry (driven from ~underflow).
- entry  in  ENTRY_SZ  lane entry from the buffer.
- entry_ready  out  1  entry is accepted this cycle when entry_valid & entry_ready.
- m_tvalid  out  1  AXIS valid.
- m_tready  in  1  AXIS ready.
- m_tdata  out  M_KEEP_WIDTH*T_DATA_WIDTH  AXIS data, lane 0 in the LSBs.
- m_tkeep  out  M_KEEP_WIDTH  AXIS keep.
- m_tlast  out  1  AXIS last.
- pkt_count  out  16  count of completed packets (tlast handshakes), wraps at 0xFFFF -> 0.

Behaviour:
- Reset:
  - rst_n low clears immediately: m_tvalid, m_tdata, m_tkeep, m_tlast, pkt_count, staging contents/count, timeout counter.
  - entry_ready = 0 while in reset.
  - Reset mid-packet discards all staged lanes with no partial beat emitted.
- Staging:
  - Holds up to 2*M_KEEP_WIDTH lanes plus a per-lane last flag, with count register scnt.
  - entry_ready = (scnt <= M_KEEP_WIDTH) after accounting for a beat leaving staging in the same cycle.
- Accept:
  - Kept lanes of the entry are appended after existing staged lanes in lane order 0..M-1.
  - Null lanes are dropped.
  - A null lane with last=1 sets last on the most recently staged lane (including lanes appended earlier in the same entry).
  - If nothing is staged, that last instead produces a beat with tkeep=0, tlast=1.
- Beat formation:
  - Beat ready when scnt >= M_KEEP_WIDTH, or any staged lane among the lowest M lanes has last.
  - Beat = lanes 0..p, where p = the first last-lane index, or M-1 if there is none.
  - tkeep has bits 0..p set; unused tdata lanes are 0; tlast = last of lane p.
  - Staging shifts down by p+1.
- Output register:
  - Loads a beat when m_tvalid==0 or (m_tvalid & m_tready).
  - m_tdata/m_tkeep/m_tlast stay stable while m_tvalid & ~m_tready.
- Latency: an entry accepted at edge N can appear on m_* after edge N+1 (one registered stage).
- Throughput: accept, beat formation and output handshake may all occur in one cycle. Sustained 1 beat/cycle with full entries and m_tready=1.
- All-null entry with no last: consumed, no output, no state change except timeout restart.
- pkt_count increments on m_tvalid & m_tready & m_tlast.

Optional Feature:
- Macro: RESIZER_TX_TIMEOUT_EN.
- Enabled:
  - A 16-bit idle counter runs while 0 < scnt < M_KEEP_WIDTH, no last is staged, and no entry is accepted.
  - On reaching TIMEOUT_CYCLES, the staged lanes are emitted as a partial beat: tkeep covers scnt lanes, tlast=0.
  - The counter clears on any accept, on emission and on reset.
- Disabled: partial lanes are held indefinitely until filled or terminated by last; no counter logic is generated.

Decomposition:
- Shared package resizer_pkg:
  - LANE_KEEP_BIT=0, LANE_LAST_BIT=1, LANE_DATA_LSB=2.
  - Function lane_sz(T_DATA_WIDTH).
  - Packed lane typedef {data, last, keep}.
  - Shared with buffer and the slave-side packer.
- Sub-module resizer_tx_stage: compaction staging register (append, last-merge, beat extract, shift). The top level holds the output register, handshake, pkt_count and timeout.

Test Plan (M_KEEP_WIDTH=2, T_DATA_WIDTH=8):
1. Entry {L0 k=1 d=A1, L1 k=1 d=A2}, m_tready=1 -> next cycle m_tvalid=1, m_tdata=0xA2A1, m_tkeep=2'b11, m_tlast=0.
2. Entries {k0, k1 B1} then {k1 B2, k0} -> exactly one beat: m_tdata=0xB2B1, m_tkeep=2'b11.
3. Entry {L0 k1 last=1 C1, L1 k1 C2}, then {k1 C3, k0 last=1} -> beat 0x00C1 keep 01 tlast=1, then beat 0xC3C2 keep 11 tlast=1; pkt_count=2.
4. m_tready=0 for 6 cycles with 4 full entries offered -> m_* stable, entry_ready falls once scnt>2; after release, beats arrive in order with no loss or duplication.
5. rst_n pulsed low mid-packet with 1 lane staged -> m_tvalid=0 and pkt_count=0 immediately, no partial beat after release, next packet clean.
6. With RESIZER_TX_TIMEOUT_EN: single kept lane D1 then idle -> beat 0x00D1 keep 01 tlast=0 after 16 idle cycles. Without the macro: no beat within 100 cycles.
